// File: rtl/siso_shift_pkg.sv
// Shared types and constants for the SISO shift controller.
// The PARITY state is only reached when SISO_SHIFT_CTRL_PARITY_EN is defined.
package siso_shift_pkg;

    // Default frame width in bits.
    localparam int DATA_W_DEFAULT = 5;

    // Values of in_dir. Each word carries its own direction.
    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/siso_bit_counter.sv
// Counts the bits of one frame.
// term is high while the last data bit (index DATA_W-1) is on the line.
module siso_bit_counter #(
    parameter int DATA_W = 5,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Clear on frame load, otherwise step once per shifted bit.
    // The counter can reach DATA_W after the last bit, so CNT_W never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign term = (cnt_reg == LAST);

endmodule

// File: rtl/siso_shift_ctrl.sv
// Sequencer for the serial-in/serial-out shift path.
// Takes a parallel word over valid/ready and sends it out one bit per clock,
// LSB or MSB first as selected per word. All outputs are registered.
// Optional feature: define SISO_SHIFT_CTRL_PARITY_EN to append an even-parity
// bit after the data bits.
module siso_shift_ctrl
    import siso_shift_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dir,
    output logic              so,
    output logic              so_en,
    output logic              busy,
    output logic              done
);

    state_t            state_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic              dir_reg;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
    logic              par_reg;
`endif

    logic accept;
    logic cnt_en;
    logic cnt_term;

    // in_ready is only ever high in IDLE; the state check keeps this robust.
    assign accept = in_valid && in_ready && (state_reg == IDLE);
    assign cnt_en = (state_reg == SHIFT);

    siso_bit_counter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (cnt_en),
        .term  (cnt_term)
    );

    // Frame sequencer: load, shift, optional parity, then back to idle with a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            dir_reg   <= DIR_LSB_FIRST;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
            par_reg   <= 1'b0;
`endif
            so        <= 1'b0;
            so_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Stay ready; done lasts a single cycle.
                    so       <= 1'b0;
                    so_en    <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                    if (accept) begin
                        shreg_reg <= in_data;
                        dir_reg   <= in_dir;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
                        par_reg   <= ^in_data;
`endif
                        so        <= (in_dir == DIR_LSB_FIRST) ? in_data[0] : in_data[DATA_W-1];
                        so_en     <= 1'b1;
                        busy      <= 1'b1;
                        in_ready  <= 1'b0;
                        state_reg <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (cnt_term) begin
`ifdef SISO_SHIFT_CTRL_PARITY_EN
                        so        <= par_reg;
                        so_en     <= 1'b1;
                        state_reg <= PARITY;
`else
                        so        <= 1'b0;
                        so_en     <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
`endif
                    end else if (dir_reg == DIR_MSB_FIRST) begin
                        so        <= shreg_reg[DATA_W-2];
                        shreg_reg <= {shreg_reg[DATA_W-2:0], 1'b0};
                    end else begin
                        so        <= shreg_reg[1];
                        shreg_reg <= {1'b0, shreg_reg[DATA_W-1:1]};
                    end
                end

`ifdef SISO_SHIFT_CTRL_PARITY_EN
                PARITY: begin
                    so        <= 1'b0;
                    so_en     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    in_ready  <= 1'b1;
                    state_reg <= IDLE;
                end
`endif

                default: begin
                    so        <= 1'b0;
                    so_en     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    in_ready  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Self-checking bench for siso_shift_ctrl with DATA_W = 5.
// The reference model schedules whole frames: on acceptance it queues one expected
// output vector per future cycle {so, so_en, busy, done, in_ready}.
module tb_siso_shift_ctrl;
    import siso_shift_pkg::*;

    localparam int W = DATA_W_DEFAULT;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam logic [4:0] IDLE_V = 5'b00001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_dir = 1'b0;
    logic         in_ready, so, so_en, busy, done;

    logic [4:0]   exp_q[$];
    logic [4:0]   exp_cur = 5'b00000;
    int           vectors = 0;
    int           errors = 0;

    siso_shift_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dir   (in_dir),
        .so       (so),
        .so_en    (so_en),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {so, so_en, busy, done, in_ready};
    endfunction

    // Expected per-cycle outputs of a whole frame.
    task automatic push_frame(input logic [W-1:0] d, input logic dr);
        for (int i = 0; i < W; i++) begin
            logic b;
            b = dr ? d[W-1-i] : d[i];
            exp_q.push_back({b, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        if (PAR != 0) exp_q.push_back({^d, 1'b1, 1'b1, 1'b0, 1'b0});
        exp_q.push_back(5'b00011);
    endtask

    // Drive one cycle of inputs, advance the model, and leave time just after the edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic dr);
        logic acc;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_dir   = dr;
        acc = v && exp_cur[0];
        @(posedge clk);
        if (acc) push_frame(d, dr);
        if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
        else                  exp_cur = IDLE_V;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (obs() !== 5'b00000) begin
            errors++;
            $display("FAIL reset_hold got so/en/busy/done/rdy=%b want %b", obs(), 5'b00000);
        end
        rst_n = 1'b1;
        exp_cur = 5'b00000;
        #1;
        vectors++;
        if (obs() !== 5'b00000) begin
            errors++;
            $display("FAIL reset_release got %b want %b", obs(), 5'b00000);
        end
        cycle(1'b0, '0, 1'b0);
        vectors++;
        if (obs() !== exp_cur) begin
            errors++;
            $display("FAIL reset_first_edge got %b want %b", obs(), exp_cur);
        end
    endtask

    // Sends one word and checks each cycle plus the serial bit order.
    task automatic test_frame(input string name, input logic [W-1:0] d, input logic dr,
                              input logic [W-1:0] want_bits);
        logic [W-1:0] cap;
        int n;
        cap = '0;
        n = 0;
        for (int c = 0; c <= W + PAR + 2; c++) begin
            cycle(c == 0, d, dr);
            vectors++;
            if (obs() !== exp_cur) begin
                errors++;
                $display("FAIL %s c%0d got %b want %b", name, c, obs(), exp_cur);
            end
            if (so_en && n < W) begin
                if (dr) cap[W-1-n] = so;
                else    cap[n] = so;
                n++;
            end
        end
        vectors++;
        if (cap !== want_bits) begin
            errors++;
            $display("FAIL %s_bits got %b want %b", name, cap, want_bits);
        end
    endtask

    task automatic test_back_to_back();
        logic en_hist[$];
        int gap;
        bit in_gap;
        bit seen_first;
        bit seen_second;
        for (int c = 0; c <= 2 * (W + PAR + 1) + 2; c++) begin
            cycle(c <= W + PAR + 1, (c == 0) ? 5'b11111 : 5'b00001, 1'b0);
            vectors++;
            if (obs() !== exp_cur) begin
                errors++;
                $display("FAIL back_to_back c%0d got %b want %b", c, obs(), exp_cur);
            end
            en_hist.push_back(so_en);
        end
        gap = 0;
        in_gap = 0;
        seen_first = 0;
        seen_second = 0;
        foreach (en_hist[i]) begin
            if (en_hist[i]) begin
                if (in_gap) seen_second = 1;
                seen_first = 1;
                in_gap = 0;
            end else if (seen_first && !seen_second) begin
                in_gap = 1;
                gap++;
            end
        end
        vectors++;
        if (!seen_second || gap != 1) begin
            errors++;
            $display("FAIL back_to_back_gap got gap=%0d second=%0d want gap=1 second=1", gap, seen_second);
        end
    endtask

    task automatic test_ignore_busy();
        logic [W-1:0] cap;
        int n;
        cap = '0;
        n = 0;
        for (int c = 0; c <= W + PAR + 2; c++) begin
            if (c == 0)      cycle(1'b1, 5'b10110, DIR_LSB_FIRST);
            else if (c == 3) cycle(1'b1, 5'b01010, DIR_MSB_FIRST);
            else             cycle(1'b0, '0, 1'b0);
            vectors++;
            if (obs() !== exp_cur) begin
                errors++;
                $display("FAIL ignore_busy c%0d got %b want %b", c, obs(), exp_cur);
            end
            if (so_en && n < W) begin
                cap[n] = so;
                n++;
            end
        end
        vectors++;
        if (cap !== 5'b10110) begin
            errors++;
            $display("FAIL ignore_busy_bits got %b want %b", cap, 5'b10110);
        end
    endtask

    task automatic test_reset_midframe();
        cycle(1'b1, 5'b11011, DIR_MSB_FIRST);
        cycle(1'b0, '0, 1'b0);
        vectors++;
        if (obs() !== exp_cur) begin
            errors++;
            $display("FAIL midreset_bit2 got %b want %b", obs(), exp_cur);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_cur = 5'b00000;
        vectors++;
        if (obs() !== exp_cur) begin
            errors++;
            $display("FAIL midreset_async got %b want %b", obs(), exp_cur);
        end
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < W + 2; c++) begin
            cycle(1'b0, '0, 1'b0);
            vectors++;
            if (obs() !== exp_cur) begin
                errors++;
                $display("FAIL midreset_after c%0d got %b want %b", c, obs(), exp_cur);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 2) != 0, W'($urandom), 1'($urandom));
            vectors++;
            if (obs() !== exp_cur) begin
                errors++;
                $display("FAIL random c%0d got %b want %b", c, obs(), exp_cur);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame("lsb_10110", 5'b10110, DIR_LSB_FIRST, 5'b10110);
        test_frame("msb_10110", 5'b10110, DIR_MSB_FIRST, 5'b10110);
        test_back_to_back();
        test_ignore_busy();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
